scc_bus_master: RTL

- Bus initiator for the SCC sound block: drives its cs / cpu_mreq / cpu_wr / cpu_addr / din lanes and samples scc_dout.
- Takes queued register accesses from a host side (HPS ioctl replay, self-test, sound-preset loader) in a small FIFO.
- Replays each access in order with fixed Z80-like strobe timing paced by clk_en.
- Returns read data on a one-cycle response strobe.

---
 rtl/scc_pkg.sv | 21 ++
 rtl/scc_req_fifo.sv | 54 +++++
 rtl/scc_bus_master.sv | 123 ++++++++++++
 3 files changed

// File: rtl/scc_pkg.sv
// rtl/scc_pkg.sv - shared types and constants for the SCC bus master
// Purpose: access record carried through the request FIFO and the bus FSM state encoding.
package scc_pkg;

  localparam int SCC_ADDR_W = 8;

  // One queued register access: {rd, addr, data} = 17 bits.
  typedef struct packed {
    logic                  rd;
    logic [SCC_ADDR_W-1:0] addr;
    logic [7:0]            data;
  } scc_acc_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    GAP
  } scc_bm_state_t;

endpackage

// File: rtl/scc_req_fifo.sv
// rtl/scc_req_fifo.sv - synchronous FIFO of queued SCC register accesses
// Purpose: holds host accesses until the bus FSM replays them, first-word-fall-through.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   push, push_data write side; ignored while full (full is evaluated before the same-cycle pop)
//   pop, pop_data   read side; pop_data always shows the head entry
//   full, empty     occupancy flags from extra-MSB pointer compare
module scc_req_fifo
  import scc_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  scc_acc_t push_data,
  input  logic     pop,
  output scc_acc_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  scc_acc_t    mem [DEPTH];

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/scc_bus_master.sv
// rtl/scc_bus_master.sv - SCC bus initiator replaying queued register accesses
// Purpose: pops host accesses from a FIFO and drives Z80-like SCC strobes paced by clk_en.
// Ports:
//   clk, reset, clk_en                      clock, sync active-high reset, bus timing tick
//   req_valid/req_ready/req_rd/addr/data    host request side
//   rsp_valid, rsp_data                     one-clk read response, data held until next read
//   busy                                    FIFO non-empty or access in flight
//   cs, cpu_mreq, cpu_wr, cpu_addr, cpu_dout registered SCC bus outputs
//   scc_din                                 SCC read data
module scc_bus_master
  import scc_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int STROBE_TICKS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rd,
  input  logic [SCC_ADDR_W-1:0] req_addr,
  input  logic [7:0]            req_data,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_data,
  output logic                  busy,
  output logic                  cs,
  output logic                  cpu_mreq,
  output logic                  cpu_wr,
  output logic [SCC_ADDR_W-1:0] cpu_addr,
  output logic [7:0]            cpu_dout,
  input  logic [7:0]            scc_din
);

  localparam int CNT_W = (STROBE_TICKS > 1) ? $clog2(STROBE_TICKS) : 1;

  scc_bm_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic             cur_rd;
  logic             full;
  logic             empty;
  logic             pop;
  scc_acc_t         head;
  scc_acc_t         push_entry;

  assign push_entry = '{rd: req_rd, addr: req_addr, data: req_data};
  assign pop        = (state == IDLE) && clk_en && !empty;
  assign req_ready  = !full;
  assign busy       = !empty || (state != IDLE);

  scc_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (req_valid),
    .push_data(push_entry),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_rd    <= 1'b0;
      cs        <= 1'b0;
      cpu_mreq  <= 1'b0;
      cpu_wr    <= 1'b0;
      cpu_addr  <= '0;
      cpu_dout  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      // Response is a single clk pulse even when clk_en stays high.
      rsp_valid <= 1'b0;
      if (clk_en) begin
        case (state)
          IDLE: begin
            cs       <= 1'b0;
            cpu_mreq <= 1'b0;
            cpu_wr   <= 1'b0;
            if (!empty) begin
              cur_rd   <= head.rd;
              cpu_addr <= head.addr;
              cpu_dout <= head.rd ? 8'h00 : head.data;
              cs       <= 1'b1;
              cpu_mreq <= 1'b1;
              state    <= SETUP;
            end
          end
          SETUP: begin
            cpu_wr <= !cur_rd;
            cnt    <= CNT_W'(STROBE_TICKS - 1);
            state  <= STROBE;
          end
          STROBE: begin
            if (cnt == '0) begin
              if (cur_rd) begin
                rsp_data  <= scc_din;
                rsp_valid <= 1'b1;
              end
              cs       <= 1'b0;
              cpu_mreq <= 1'b0;
              cpu_wr   <= 1'b0;
              state    <= GAP;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          GAP: begin
            // Address and data lanes keep their last values here.
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
